// File: rtl/mdio_master_cfg_if.sv
// MDIO master bundle: host request/response plus the MDC/MDIO pins.
// master: the MDIO controller side; slave: host/PHY side (testbench).
interface mdio_master_cfg_if;
    logic        start_stb;
    logic [31:0] transaccion;
    logic        mdio_in;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic [15:0] rd_data;
    logic        data_rdy;
    logic        busy;
    logic        ta_err;

    modport master (
        input  start_stb, transaccion, mdio_in,
        output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, ta_err
    );

    modport slave (
        output start_stb, transaccion, mdio_in,
        input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, ta_err
    );
endinterface

// File: rtl/mdio_master_cfg.sv
// MDIO management master: preamble + 32-bit Clause 22/45 frame, MDC divider,
// read capture with turnaround check.
// Ports: clk, reset (async active-low), bus (mdio_master_cfg_if.master):
//   start_stb/transaccion request, mdio_in from PHY, mdc/mdio_out/mdio_oe pins,
//   rd_data/data_rdy/busy/ta_err status.
module mdio_master_cfg #(
    parameter int CLK_DIV      = 1,
    parameter int PREAMBLE_LEN = 32
) (
    input logic               clk,
    input logic               reset,
    mdio_master_cfg_if.master bus
);
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [5:0]    PRE_LAST = 6'(PREAMBLE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [PW-1:0] r_ph;
    logic [5:0]  r_bit;
    logic [31:0] r_sh;
    logic        r_rd;
    logic        r_terr;
    logic [15:0] r_cap;
    logic [15:0] r_rd_data;
    logic        r_ta_err;

    logic        w_in_bit;
    logic        w_bit_end;
    logic        w_sample;
    logic        w_mdc;
    logic        w_out;
    logic        w_oe;
    logic        w_is_rd;
    logic [15:0] w_cap_nx;

    always_comb begin
        w_state_nx = r_state;
        w_in_bit   = (r_state == S_PRE) || (r_state == S_HDR) ||
                     (r_state == S_TA)  || (r_state == S_DATA);
        w_bit_end  = w_in_bit && (r_ph == PH_LAST);
        // mdio_in is taken in the cycle where MDC rises
        w_sample   = w_in_bit && (r_ph == PH_HALF);
        w_mdc      = w_in_bit && (r_ph >= PH_HALF);
        w_out      = 1'b0;
        w_oe       = 1'b0;
        w_cap_nx   = r_cap;
        w_is_rd    = (bus.transaccion[31:30] == 2'b01 &&
                      bus.transaccion[29:28] == 2'b10) ||
                     (bus.transaccion[31:30] == 2'b00 &&
                      bus.transaccion[29]);
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_stb)
                    w_state_nx = (PREAMBLE_LEN == 0) ? S_HDR : S_PRE;
            end
            S_PRE: begin
                w_out = 1'b1;
                w_oe  = 1'b1;
                if (w_bit_end && r_bit == PRE_LAST)
                    w_state_nx = S_HDR;
            end
            S_HDR: begin
                w_out = r_sh[31];
                w_oe  = 1'b1;
                if (w_bit_end && r_bit == 6'd13)
                    w_state_nx = S_TA;
            end
            S_TA: begin
                // reads release the line for the PHY from TA onward
                w_out = r_sh[31] & ~r_rd;
                w_oe  = ~r_rd;
                if (w_bit_end && r_bit == 6'd15)
                    w_state_nx = S_DATA;
            end
            S_DATA: begin
                w_out = r_sh[31] & ~r_rd;
                w_oe  = ~r_rd;
                if (w_sample && r_rd)
                    w_cap_nx = {r_cap[14:0], bus.mdio_in};
                if (w_bit_end && r_bit == 6'd31)
                    w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ph      <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_rd      <= 1'b0;
            r_terr    <= 1'b0;
            r_cap     <= '0;
            r_rd_data <= '0;
            r_ta_err  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cap   <= w_cap_nx;
            if (r_state == S_IDLE) begin
                r_ph  <= '0;
                r_bit <= '0;
                if (bus.start_stb) begin
                    r_sh   <= bus.transaccion;
                    r_rd   <= w_is_rd;
                    r_terr <= 1'b0;
                end
            end else if (w_in_bit) begin
                if (w_bit_end) begin
                    r_ph <= '0;
                    // frame bit index runs 0..31 across HDR/TA/DATA
                    if (r_state == S_PRE && w_state_nx == S_HDR)
                        r_bit <= '0;
                    else
                        r_bit <= r_bit + 6'd1;
                    if (r_state != S_PRE)
                        r_sh <= {r_sh[30:0], 1'b0};
                end else begin
                    r_ph <= r_ph + 1'b1;
                end
                if (r_state == S_TA && r_bit == 6'd15 &&
                    w_sample && r_rd && bus.mdio_in)
                    r_terr <= 1'b1;
                // status is valid during the data_rdy cycle
                if (r_state == S_DATA && w_state_nx == S_DONE && r_rd) begin
                    if (r_terr) begin
                        r_ta_err <= 1'b1;
                    end else begin
                        r_rd_data <= w_cap_nx;
                        r_ta_err  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.mdc      = w_mdc;
    assign bus.mdio_out = w_out;
    assign bus.mdio_oe  = w_oe;
    assign bus.busy     = w_in_bit;
    assign bus.data_rdy = (r_state == S_DONE);
    assign bus.rd_data  = r_rd_data;
    assign bus.ta_err   = r_ta_err;
endmodule

// File: tb/tb_mdio_master_cfg.sv
// Bench for mdio_master_cfg: default instance and CLK_DIV=3/no-preamble
// instance, checked against a frame-level model of the MDIO bit stream.
module tb_mdio_master_cfg;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   g_sel;

    logic [15:0] m_rd[2];
    logic        m_ta[2];

    mdio_master_cfg_if ia();
    mdio_master_cfg_if ib();

    mdio_master_cfg #(.CLK_DIV(1), .PREAMBLE_LEN(32)) u_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ia)
    );

    mdio_master_cfg #(.CLK_DIV(3), .PREAMBLE_LEN(0)) u_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        o_mdc, o_out, o_oe, o_rdy, o_busy, o_ta;
    logic [15:0] o_rd;
    assign o_mdc  = (g_sel != 0) ? ib.mdc      : ia.mdc;
    assign o_out  = (g_sel != 0) ? ib.mdio_out : ia.mdio_out;
    assign o_oe   = (g_sel != 0) ? ib.mdio_oe  : ia.mdio_oe;
    assign o_rdy  = (g_sel != 0) ? ib.data_rdy : ia.data_rdy;
    assign o_busy = (g_sel != 0) ? ib.busy     : ia.busy;
    assign o_ta   = (g_sel != 0) ? ib.ta_err   : ia.ta_err;
    assign o_rd   = (g_sel != 0) ? ib.rd_data  : ia.rd_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic stb,
                         input logic [31:0] fr, input logic din);
        if (sel != 0) begin
            ib.start_stb   = stb;
            ib.transaccion = fr;
            ib.mdio_in     = din;
        end else begin
            ia.start_stb   = stb;
            ia.transaccion = fr;
            ia.mdio_in     = din;
        end
    endtask

    task automatic check_zero(input string who);
        chk({who, ":rst_mdc"},  {31'd0, o_mdc},  32'd0);
        chk({who, ":rst_out"},  {31'd0, o_out},  32'd0);
        chk({who, ":rst_oe"},   {31'd0, o_oe},   32'd0);
        chk({who, ":rst_rdy"},  {31'd0, o_rdy},  32'd0);
        chk({who, ":rst_busy"}, {31'd0, o_busy}, 32'd0);
        chk({who, ":rst_ta"},   {31'd0, o_ta},   32'd0);
        chk({who, ":rst_rd"},   {16'd0, o_rd},   32'd0);
    endtask

    // One complete transaction; the model derives every expected pin value
    // from the bit index, the frame and the read/write rule.
    task automatic frame(input int sel, input string tag,
                         input logic [31:0] fr, input logic [15:0] phy,
                         input logic ta2, input bit dup, input bit at_done);
        int   d, p, n, k, ph, j;
        int   e_mdc, e_out, e_oe, e_busy, n_rdy;
        bit   rd;
        logic x_out, x_oe, din;
        e_mdc = 0; e_out = 0; e_oe = 0; e_busy = 0; n_rdy = 0;
        g_sel = sel;
        d = (sel != 0) ? 3 : 1;
        p = (sel != 0) ? 0 : 32;
        n = (p + 32) * 2 * d;
        rd = (fr[31:30] == 2'b01 && fr[29:28] == 2'b10) ||
             (fr[31:30] == 2'b00 && fr[29]);
        drive(sel, 1'b1, fr, 1'($urandom));
        @(posedge clk); #1;
        for (int c = 1; c <= n + 1; c++) begin
            if (o_rdy === 1'b1) n_rdy++;
            if (c <= n) begin
                k  = (c - 1) / (2 * d);
                ph = (c - 1) % (2 * d);
                j  = k - p;
                if (j < 0) begin
                    x_out = 1'b1; x_oe = 1'b1;
                end else if (rd && j >= 14) begin
                    x_out = 1'b0; x_oe = 1'b0;
                end else begin
                    x_out = fr[31 - j]; x_oe = 1'b1;
                end
                if (o_mdc !== (ph >= d)) e_mdc++;
                if (o_out !== x_out) e_out++;
                if (o_oe !== x_oe) e_oe++;
                if (o_busy !== 1'b1) e_busy++;
                din = 1'($urandom);
                if (ph == d && j == 15) din = ta2;
                if (ph == d && j >= 16) din = phy[31 - j];
                drive(sel, dup && c == 10, $urandom, din);
            end else begin
                if (rd) begin
                    if (ta2) m_ta[sel] = 1'b1;
                    else begin
                        m_rd[sel] = phy;
                        m_ta[sel] = 1'b0;
                    end
                end
                chk({tag, ":done_busy"}, {31'd0, o_busy}, 32'd0);
                chk({tag, ":done_oe"},   {31'd0, o_oe},   32'd0);
                chk({tag, ":done_mdc"},  {31'd0, o_mdc},  32'd0);
                chk({tag, ":rd_data"},   {16'd0, o_rd},   {16'd0, m_rd[sel]});
                chk({tag, ":ta_err"},    {31'd0, o_ta},   {31'd0, m_ta[sel]});
                chk({tag, ":rdy_at_lat"}, {31'd0, o_rdy}, 32'd1);
                drive(sel, at_done, $urandom, 1'($urandom));
            end
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, $urandom, 1'($urandom));
        chk({tag, ":mdc_cycles"},  e_mdc,  0);
        chk({tag, ":out_cycles"},  e_out,  0);
        chk({tag, ":oe_cycles"},   e_oe,   0);
        chk({tag, ":busy_cycles"}, e_busy, 0);
        chk({tag, ":rdy_count"},   n_rdy,  1);
        chk({tag, ":idle_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, ":idle_rdy"},  {31'd0, o_rdy},  32'd0);
    endtask

    initial begin
        logic [31:0] fr;
        int n_rdy;
        total = 0;
        bad = 0;
        g_sel = 0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_ta[0] = 1'b0; m_ta[1] = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        g_sel = 0; check_zero("A");
        g_sel = 1; check_zero("B");
        rst_n = 1'b1;
        @(posedge clk); #1;

        frame(0, "wr55", 32'h5555_5555, 16'h0, 1'b0, 0, 0);
        frame(0, "c22rd", 32'h6555_7777, 16'h2468, 1'b0, 0, 0);
        frame(0, "taerr", 32'h6555_7777, 16'h1357, 1'b1, 0, 0);
        fr = $urandom;
        frame(0, "c45rd", {4'h3, fr[27:0]}, 16'hBEEF, 1'b0, 0, 0);
        frame(0, "dupstb", {4'h5, fr[27:0]}, 16'h0, 1'b0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            fr = $urandom;
            frame(0, $sformatf("randA%0d", i), fr, 16'($urandom),
                  1'($urandom), 0, 0);
        end

        // reset in the middle of the DATA phase of a read
        g_sel = 0;
        drive(0, 1'b1, 32'h6AAA_0000, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0);
        repeat (105) @(posedge clk);
        #1;
        chk("midrst:busy_before", {31'd0, o_busy}, 32'd1);
        chk("midrst:mdc_before",  {31'd0, o_mdc},  32'd1);
        rst_n = 1'b0;
        #1;
        m_rd[0] = '0; m_ta[0] = 1'b0;
        m_rd[1] = '0; m_ta[1] = 1'b0;
        check_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_rdy = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_rdy === 1'b1) n_rdy++;
            if (o_busy === 1'b1) n_rdy++;
            @(posedge clk); #1;
        end
        chk("midrst:no_rdy_busy", n_rdy, 0);

        fr = $urandom;
        frame(1, "B_wr", {4'h5, fr[27:0]}, 16'h0, 1'b0, 0, 0);
        fr = $urandom;
        frame(1, "B_rd", {4'h6, fr[27:0]}, 16'($urandom), 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            fr = $urandom;
            frame(1, $sformatf("randB%0d", i), fr, 16'($urandom),
                  1'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdio_master_cfg.md
Name: mdio_master_cfg

Overview:
Parametrised MDIO management master, the next generation of our fixed-frame MDIO generator. It serialises a 32-bit MDIO frame after a configurable preamble and generates MDC from the system clock through a programmable divider. It supports both Clause 22 and Clause 45 frame types. Read data is captured and returned with a completion strobe, and the PHY turnaround response is checked.

Parameters:
CLK_DIV, 1, clk cycles per MDC half-period (legal range ≥1); one bit period = 2*CLK_DIV clk cycles.
PREAMBLE_LEN, 32, number of preamble '1' bits sent before the frame (legal range 0..32).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous reset, active-low.
start_stb  input  1  start request; sampled only while busy=0.
transaccion  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data/address; sent MSB first.
mdio_in  input  1  MDIO line value driven by the PHY.
mdc  output  1  management clock.
mdio_out  output  1  serial MDIO data out.
mdio_oe  output  1  output enable for mdio_out.
rd_data  output  16  data captured by the last read without error.
data_rdy  output  1  one-clk pulse at transaction end.
busy  output  1  high while a transaction is in progress.
ta_err  output  1  turnaround error of the last read; updated at each read completion.

Behaviour:
- Reset (reset=0, async) forces:
  - outputs: mdc=0, mdio_out=0, mdio_oe=0, rd_data=0, data_rdy=0, busy=0, ta_err=0;
  - FSM to IDLE and all counters to 0.
  - Reset mid-frame aborts the transaction immediately. No data_rdy is produced.
- FSM states: IDLE, PREAMBLE, HDR (14 bits ST..REGAD), TA (2 bits), DATA (16 bits), DONE.
- IDLE:
  - start_stb=1 latches transaccion into a shadow register, sets busy=1 and enters PREAMBLE.
  - If PREAMBLE_LEN=0, IDLE goes directly to HDR.
  - start_stb while busy=1 is ignored; the latched frame is never altered mid-transaction.
- Bit timing:
  - Each bit period begins with mdc=0 for CLK_DIV clk cycles, then mdc=1 for CLK_DIV cycles.
  - mdio_out/mdio_oe change only at the start of a bit period, i.e. on the falling MDC edge.
  - mdio_in is sampled in the clk cycle in which mdc goes 0->1.
  - mdc stays 0 in IDLE and DONE.
- Read detection: read when (ST=01 and OP=10) or (ST=00 and OP[1]=1). All other combinations are writes.
- Write: mdio_oe=1 for every preamble and frame bit; mdio_out = preamble 1s, then transaccion[31:0].
- Read:
  - mdio_oe=1 through HDR.
  - mdio_oe=0 from the start of TA bit 1 until the end of DATA.
  - mdio_out=0 while oe=0.
  - TA bit 2 sample must be 0; otherwise the ta_err flag is set for this transaction.
  - DATA samples shift MSB-first into a capture register.
- DONE, one clk long:
  - data_rdy=1, busy=0, mdio_oe=0, then return to IDLE.
  - For a read without error: rd_data updated, ta_err=0.
  - For a read with error: ta_err=1, rd_data kept.
  - Writes leave rd_data and ta_err unchanged.
- Latency: start_stb cycle to data_rdy = 1 + (PREAMBLE_LEN+32)*2*CLK_DIV clk cycles. A new start_stb is accepted in the cycle after DONE.
- start_stb coinciding with DONE is ignored.

Test Plan:
- Write with defaults, transaccion=32'h55555555, start_stb for 1 clk:
  - mdio_oe=1 for 64 bit periods; mdio_out = 32 ones then 0101...01;
  - busy high 128 clks; one data_rdy pulse; rd_data=0, ta_err=0.
- Clause 22 read, transaccion=32'h65557777, bench drives 0 on TA2 then 16'h2468 on mdio_in:
  - oe drops after bit 46; rd_data=16'h2468, ta_err=0, data_rdy pulse.
- TA error: same read but PHY drives 1 on TA2 -> ta_err=1, rd_data keeps 16'h2468.
- Clause 45 read, transaccion=32'h3...: ST=00, OP=11, bench returns 16'hBEEF -> oe released at TA, rd_data=16'hBEEF.
- Second start_stb 10 clks into a transaction -> ignored; exactly one data_rdy.
- Reset asserted mid-DATA -> all outputs 0 immediately; no data_rdy.
- Separate instance with CLK_DIV=3, PREAMBLE_LEN=0:
  - mdc period 6 clks; first frame bit with no preamble;
  - data_rdy 193 clks after start_stb.
